unidad_control: RTL
===================

// Module: unidad_control
// PURPOSE
//  Hardwired control unit feeding the 16-bit control word, constant and flags loop of unidad_procesadora.
//  Fetches 16-bit instructions from a sync-read instruction memory, decodes them and drives one datapath
//  op per instruction. Registers datapath flags and resolves conditional branches. Sequences FETCH/DECODE/EXEC.
// PARAMETERS
//  PC_W      8   program counter / imem address width (>=8)
//  RST_PC    0   PC value loaded on reset
// PORTS
//  clk          in   1     single clock, all state on rising edge
//  rst_n        in   1     synchronous, active-low reset
//  imem_addr    out  PC_W  instruction address (= pc)
//  imem_data    in   16    instruction; valid 1 cycle after imem_addr (sync read)
//  flags        in   4     datapath flags {V,C,N,Z}, combinational from current op
//  control      out  16    {A[2],B[2],dest[2],we,MB,alu[4],sh[2],MF,MD} to datapath
//  Constant_IN  out  4     immediate to datapath constant input
//  mem_we       out  1     data memory write strobe (ST), addr=adr_out, data=dataout
//  halted       out  1     high while in HALT
// BEHAVIOUR
//  Instr: [15:12]op [11:10]rd [9:8]ra [7:6]rb [5:2]imm [1:0]cond.
//  FSM: FETCH -> DECODE -> EXEC -> FETCH; EXEC(HALT op) -> HALT (sticky until reset).
//   FETCH: imem_addr=pc. DECODE: IR<=imem_data, pc<=pc+1 (mod 2^PC_W). EXEC: control driven 1 cycle.
//   3 cycles per instruction; first EXEC is cycle 3 after rst_n deasserts.
//  Outside EXEC: control=16'h0000, Constant_IN=0, mem_we=0 (no register write).
//  ALU codes: PASSA 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, XOR 0101, PASSB 0110. sh: 00 pass, 01 shl, 10 shr.
//  Ops (A=ra,B=rb,dest=rd, Constant_IN=imm in every EXEC):
//   0 NOP: we=0 | 1 ADD,2 SUB,3 AND,4 OR,5 XOR: we=1,MB=0,MF=0,MD=0 | 6 ADDI: ADD with MB=1
//   7 SHL/8 SHR: we=1,MF=1,sh=01/10, B=rb | 9 LD: we=1,MD=1 | A ST: we=0,mem_we=1
//   B LDI: we=1,MB=1,alu=PASSB | C BR | D JMP | E reserved = NOP | F HALT.
//  Flag register flg: reset 0; updated from flags at end of EXEC for ops 1-8 only; LD/LDI/others hold.
//  BR: taken if flg[cond] (cond 0=Z,1=N,2=C,3=V); pc <= pc + sext({rb,imm}) (6-bit signed, relative to
//   already-incremented pc), wraps mod 2^PC_W. Not taken: pc unchanged. control=0 during BR/JMP EXEC.
//  JMP: pc <= zero-extend(IR[9:2]) truncated to PC_W.
//  HALT: halted=1, pc frozen, control=0, imem_addr=pc of instr after HALT.
//  Reset (any state, any cycle): state=FETCH, pc=RST_PC, IR=0, flg=0, all outputs at idle values above.
// CONFIGURATION
//  UCONTROL_SINGLE_STEP_EN defined: adds input port step (1 bit). FSM waits in FETCH until step=1 is
//   sampled; one instruction executes per step pulse (level held = free run). HALT unaffected.
//  Not defined: no step port; FSM free-runs FETCH->DECODE->EXEC continuously.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> imem_addr=0, control=0, mem_we=0, halted=0; release -> first EXEC at cycle 3.
//  2 LDI r1,5 (16'hB414) -> EXEC control: dest=01,we=1,MB=1,alu=0110; Constant_IN=4'h5; pc=1 after.
//  3 SUB r2,r1,r1 with flags=4'b0001 in EXEC, then BR Z,+3 at pc=1 -> flg[0]=1, pc 2->5.
//  4 BR Z with flg=0 -> pc increments only; offset -1 (6'h3F) from pc=0 -> pc wraps to 8'hFF... taken check.
//  5 ST r0,r3 -> mem_we=1 only in its EXEC cycle, we=0; HALT -> halted=1, pc and outputs frozen 10 cycles.
//  6 rst_n=0 during DECODE of ADD -> next cycle FETCH, pc=RST_PC, flg=0, no we pulse emitted.

Source files
------------

// File: rtl/unidad_control.sv
// rtl/unidad_control.sv - hardwired FETCH/DECODE/EXEC control unit for unidad_procesadora
// Optional build macro: UCONTROL_SINGLE_STEP_EN adds the step input for single-instruction stepping.
module unidad_control #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef UCONTROL_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [3:0]      flags,
    output logic [15:0]     control,
    output logic [3:0]      Constant_IN,
    output logic            mem_we,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b0110;
    localparam logic [1:0] SH_PASS   = 2'b00;
    localparam logic [1:0] SH_LEFT   = 2'b01;
    localparam logic [1:0] SH_RIGHT  = 2'b10;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [15:0]     ir;
    logic [3:0]      flg, flg_nx;

    logic [3:0] op;
    logic [1:0] rd, ra, rb, cond;
    logic       c_fields, c_we, c_mb, c_mf, c_md;
    logic [3:0] c_alu;
    logic [1:0] c_sh;

    assign op        = ir[15:12];
    assign rd        = ir[11:10];
    assign ra        = ir[9:8];
    assign rb        = ir[7:6];
    assign cond      = ir[1:0];
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RST_PC;
            ir    <= 16'h0000;
            flg   <= 4'h0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            flg   <= flg_nx;
            if (state == S_DECODE) begin
                ir <= imem_data;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        flg_nx      = flg;
        Constant_IN = 4'h0;
        mem_we      = 1'b0;
        halted      = 1'b0;
        c_fields    = 1'b0;
        c_we        = 1'b0;
        c_mb        = 1'b0;
        c_mf        = 1'b0;
        c_md        = 1'b0;
        c_alu       = ALU_PASSA;
        c_sh        = SH_PASS;

        case (state)
            S_FETCH: begin
`ifdef UCONTROL_SINGLE_STEP_EN
                if (step) begin
                    state_nx = S_DECODE;
                end
`else
                state_nx = S_DECODE;
`endif
            end
            S_DECODE: begin
                state_nx = S_EXEC;
                pc_nx    = pc + PC_W'(1);
            end
            S_EXEC: begin
                state_nx    = (op == OP_HALT) ? S_HALT : S_FETCH;
                Constant_IN = ir[5:2];
                c_fields    = 1'b1;
                case (op)
                    // Register-register opcodes share their encoding with the ALU code.
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        c_we  = 1'b1;
                        c_alu = op;
                    end
                    OP_ADDI: begin
                        c_we  = 1'b1;
                        c_mb  = 1'b1;
                        c_alu = ALU_ADD;
                    end
                    OP_SHL: begin
                        c_we = 1'b1;
                        c_mf = 1'b1;
                        c_sh = SH_LEFT;
                    end
                    OP_SHR: begin
                        c_we = 1'b1;
                        c_mf = 1'b1;
                        c_sh = SH_RIGHT;
                    end
                    OP_LD: begin
                        c_we = 1'b1;
                        c_md = 1'b1;
                    end
                    OP_ST: mem_we = 1'b1;
                    OP_LDI: begin
                        c_we  = 1'b1;
                        c_mb  = 1'b1;
                        c_alu = ALU_PASSB;
                    end
                    // pc already points past the branch, so the offset is relative to it.
                    OP_BR: begin
                        c_fields = 1'b0;
                        if (flg[cond]) begin
                            pc_nx = pc + PC_W'($signed(ir[7:2]));
                        end
                    end
                    OP_JMP: begin
                        c_fields = 1'b0;
                        pc_nx    = PC_W'(ir[9:2]);
                    end
                    OP_HALT: c_fields = 1'b0;
                    default: ;
                endcase
                if (op >= OP_ADD && op <= OP_SHR) begin
                    flg_nx = flags;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_nx = S_FETCH;
        endcase

        control = c_fields ? {ra, rb, rd, c_we, c_mb, c_alu, c_sh, c_mf, c_md} : 16'h0000;
    end

    logic unused_nop;
    assign unused_nop = (op == OP_NOP);

endmodule
